// File: rtl/bsg_lru_pseudo_tree_tracker_if.sv
// Request/response bundle for the pseudo-LRU tracker: touch, invalidate and
// lookup requests in, one-cycle-latency victim response out.
interface bsg_lru_pseudo_tree_tracker_if #(
  parameter int ways_p = 16,
  parameter int els_p  = 8
);
  localparam int lg_ways = $clog2(ways_p);
  localparam int lg_els  = (els_p <= 1) ? 1 : $clog2(els_p);

  logic               touch_v;
  logic [lg_els-1:0]  touch_set;
  logic [lg_ways-1:0] touch_way;
  logic               inv_v;
  logic [lg_els-1:0]  inv_set;
  logic [lg_ways-1:0] inv_way;
  logic               lookup_v;
  logic [lg_els-1:0]  lookup_set;
  logic               victim_v;
  logic [lg_ways-1:0] victim_way;
  logic               victim_invalid;

  modport master (
    output touch_v, touch_set, touch_way,
    output inv_v, inv_set, inv_way,
    output lookup_v, lookup_set,
    input  victim_v, victim_way, victim_invalid
  );

  modport slave (
    input  touch_v, touch_set, touch_way,
    input  inv_v, inv_set, inv_way,
    input  lookup_v, lookup_set,
    output victim_v, victim_way, victim_invalid
  );
endinterface

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Per-set tree pseudo-LRU plus valid bits; picks the lowest invalid way, else
// the tree's LRU leaf. Victim reflects same-cycle touch/invalidate (write-first).
module bsg_lru_pseudo_tree_tracker #(
  parameter int ways_p = 16,
  parameter int els_p  = 8
) (
  input logic clk_i,
  input logic reset_i,
  bsg_lru_pseudo_tree_tracker_if.slave bus
);
  localparam int lg_ways = $clog2(ways_p);
  localparam int lg_els  = (els_p <= 1) ? 1 : $clog2(els_p);

  logic [ways_p-2:0] tree_q  [els_p];
  logic [ways_p-2:0] tree_d  [els_p];
  logic [ways_p-1:0] valid_q [els_p];
  logic [ways_p-1:0] valid_d [els_p];

  logic               victim_v_q;
  logic [lg_ways-1:0] victim_way_q, victim_way_d;
  logic               victim_inv_q, victim_inv_d;

  logic [lg_els-1:0]  ts, is, ls;
  logic [lg_ways-1:0] node_t, tw, node_l, walk_way, inv_way;
  logic               dir, b, any_inv;
  logic [ways_p-2:0]  lt;
  logic [ways_p-1:0]  lv;

  // A single set has no meaningful index, so set inputs are forced to zero.
  assign ts = (els_p == 1) ? '0 : bus.touch_set;
  assign is = (els_p == 1) ? '0 : bus.inv_set;
  assign ls = (els_p == 1) ? '0 : bus.lookup_set;

  always_comb begin
    tree_d   = tree_q;
    valid_d  = valid_q;
    node_t   = '0;
    tw       = bus.touch_way;
    dir      = 1'b0;
    node_l   = '0;
    walk_way = '0;
    b        = 1'b0;
    any_inv  = 1'b0;
    inv_way  = '0;
    lt       = '0;
    lv       = '0;

    if (bus.touch_v) begin
      for (int l = 0; l < lg_ways; l++) begin
        dir = tw[lg_ways-1];
        tree_d[ts][node_t] = ~dir;
        node_t = lg_ways'({node_t, 1'b1} + {{lg_ways{1'b0}}, dir});
        tw = tw << 1;
      end
      valid_d[ts][bus.touch_way] = 1'b1;
    end

    // Applied after the touch so invalidate wins on a same-way collision.
    if (bus.inv_v)
      valid_d[is][bus.inv_way] = 1'b0;

    lt = tree_d[ls];
    lv = valid_d[ls];

    for (int w = ways_p - 1; w >= 0; w--) begin
      if (!lv[w]) begin
        any_inv = 1'b1;
        inv_way = lg_ways'(w);
      end
    end

    for (int l = 0; l < lg_ways; l++) begin
      b = lt[node_l];
      walk_way = lg_ways'({walk_way, b});
      node_l = lg_ways'({node_l, 1'b1} + {{lg_ways{1'b0}}, b});
    end

    victim_way_d = any_inv ? inv_way : walk_way;
    victim_inv_d = any_inv;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < els_p; s++) begin
        tree_q[s]  <= '0;
        valid_q[s] <= '0;
      end
      victim_v_q   <= 1'b0;
      victim_way_q <= '0;
      victim_inv_q <= 1'b0;
    end else begin
      tree_q     <= tree_d;
      valid_q    <= valid_d;
      victim_v_q <= bus.lookup_v;
      if (bus.lookup_v) begin
        victim_way_q <= victim_way_d;
        victim_inv_q <= victim_inv_d;
      end
    end
  end

  assign bus.victim_v       = victim_v_q;
  assign bus.victim_way     = victim_way_q;
  assign bus.victim_invalid = victim_inv_q;
endmodule

// File: tb/tb_bsg_lru_pseudo_tree_tracker.sv
// Randomized and directed check of the pseudo-LRU tracker (4 ways, 2 sets)
// against a heap-indexed behavioural model.
module tb_bsg_lru_pseudo_tree_tracker;
  localparam int WAYS = 4;
  localparam int SETS = 2;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bsg_lru_pseudo_tree_tracker_if #(.ways_p(WAYS), .els_p(SETS)) bus ();

  bsg_lru_pseudo_tree_tracker #(.ways_p(WAYS), .els_p(SETS)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tree nodes in heap order, leaf of way w is heap node w+WAYS-1.
  int mtree  [SETS][WAYS-1];
  int mvalid [SETS][WAYS];
  int exp_v, exp_way, exp_inv;
  bit started = 0;

  function automatic void model_touch(int s, int w);
    int n, p;
    n = w + WAYS - 1;
    while (n > 0) begin
      p = (n - 1) / 2;
      mtree[s][p] = (n == 2 * p + 2) ? 0 : 1;
      n = p;
    end
    mvalid[s][w] = 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      foreach (mtree[s, n]) mtree[s][n] = 0;
      foreach (mvalid[s, w]) mvalid[s][w] = 0;
      exp_v = 0; exp_way = 0; exp_inv = 0;
    end else if (started) begin
      if (bus.touch_v) model_touch(int'(bus.touch_set), int'(bus.touch_way));
      if (bus.inv_v) mvalid[bus.inv_set][bus.inv_way] = 0;
      exp_v = bus.lookup_v;
      if (bus.lookup_v) begin
        int s, n, found;
        s = int'(bus.lookup_set);
        found = -1;
        for (int w = WAYS - 1; w >= 0; w--)
          if (mvalid[s][w] == 0) found = w;
        if (found >= 0) begin
          exp_way = found; exp_inv = 1;
        end else begin
          n = 0;
          while (n < WAYS - 1) n = 2 * n + 1 + mtree[s][n];
          exp_way = n - (WAYS - 1); exp_inv = 0;
        end
      end
    end
    #1;
    if (started) begin
      chk("model_v", int'(bus.victim_v), exp_v);
      chk("model_way", int'(bus.victim_way), exp_way);
      chk("model_inv", int'(bus.victim_invalid), exp_inv);
    end
  end

  task automatic tick(input bit rst, input bit tv, input bit tset, input bit [1:0] tway,
                      input bit iv, input bit iset, input bit [1:0] iway,
                      input bit lv, input bit lset);
    reset = rst;
    bus.touch_v = tv; bus.touch_set = tset; bus.touch_way = tway;
    bus.inv_v = iv; bus.inv_set = iset; bus.inv_way = iway;
    bus.lookup_v = lv; bus.lookup_set = lset;
    @(negedge clk);
  endtask

  task automatic pin(input string name, input int v, input int way, input int inv);
    chk({name, "_v"}, int'(bus.victim_v), v);
    chk({name, "_way"}, int'(bus.victim_way), way);
    chk({name, "_inv"}, int'(bus.victim_invalid), inv);
  endtask

  initial begin
    reset = 1'b1;
    bus.touch_v = 0; bus.touch_set = 0; bus.touch_way = 0;
    bus.inv_v = 0; bus.inv_set = 0; bus.inv_way = 0;
    bus.lookup_v = 1; bus.lookup_set = 0;
    @(negedge clk);
    @(negedge clk);
    pin("reset", 0, 0, 0);

    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    pin("first_lookup", 1, 0, 1);

    for (int w = 0; w < WAYS; w++) tick(0, 1, 0, 2'(w), 0, 0, 0, 0, 0);
    pin("hold_after_touch", 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    pin("all_touched_set0", 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 1);
    pin("set1_untouched", 1, 0, 1);

    tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    pin("plru_not_true_lru", 1, 2, 0);

    tick(0, 0, 0, 0, 1, 0, 3, 1, 0);
    pin("inv_bypass", 1, 3, 1);

    tick(0, 1, 0, 1, 1, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    pin("touch_inv_same_way", 1, 1, 1);
    tick(0, 1, 0, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 3, 0, 0, 0, 1, 0);
    pin("tree_after_collision", 1, 0, 0);

    for (int c = 0; c < 8; c++) begin
      tick(c == 4, 0, 0, 0, 0, 0, 0, 1, 0);
      if (c == 4) pin("reset_cancel", 0, 0, 0);
      else if (c > 4) pin("post_reset_lookup", 1, 0, 1);
      else chk("stream_v", int'(bus.victim_v), 1);
    end

    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 79) == 0,
           1'($urandom), 1'($urandom), 2'($urandom),
           $urandom_range(0, 3) == 0, 1'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom));
    end

    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
